// File: rtl/rom_responder.sv
// rom_responder: 4001-style program ROM with one I/O port on the 4-bit multiplexed instruction bus.
// Follows the 8-phase cycle from SYNC, answers fetches for CHIP_ID and handles SRC/WRR/RDR.
module rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0,
    parameter logic [3:0] IO_RST  = 4'h0
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       SYNC,
    input  logic       CM_ROM,
    input  logic [3:0] DATA_I,
    output logic [3:0] DATA_O,
    output logic       DATA_OE,
    input  logic [3:0] IO_IN,
    output logic [3:0] IO_OUT,
    input  logic       LD_WE,
    input  logic [7:0] LD_ADDR,
    input  logic [7:0] LD_DATA
);
    typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
    phase_t phase_q, phase_d;
    logic [7:0] mem_q [256];
    logic [7:0] addr_q, addr_d, byte_q, byte_d, rd;
    logic [3:0] data_q, data_d, io_q, io_d, opa_q, opa_d;
    logic oe_q, oe_d, sel_q, sel_d, src_q, src_d, pend_q, pend_d;
    logic abort, hit, rdr, wrr;
    assign rd = mem_q[addr_q];
    assign DATA_O = data_q;
    assign DATA_OE = oe_q;
    assign IO_OUT = io_q;
    always_comb begin
        phase_d = SYNC ? A1 : phase_q == IDLE ? IDLE : phase_q == X3 ? A1 : phase_t'(phase_q + 4'd1);
        abort = SYNC && phase_q != X3 && phase_q != IDLE;
        hit = DATA_I == CHIP_ID;
        rdr = pend_q && opa_q == 4'hA && src_q;
        wrr = pend_q && opa_q == 4'h2 && src_q;
        addr_d = addr_q;
        byte_d = byte_q;
        sel_d = sel_q;
        src_d = src_q;
        pend_d = pend_q;
        opa_d = opa_q;
        io_d = io_q;
        data_d = 4'h0;
        oe_d = 1'b0;
        case (phase_q)
            A1: addr_d[3:0] = DATA_I;
            A2: addr_d[7:4] = DATA_I;
            // whole byte captured here so later loads cannot split the opcode
            A3: begin
                sel_d = hit;
                byte_d = rd;
                oe_d = hit;
                data_d = hit ? rd[7:4] : 4'h0;
            end
            M1: begin
                oe_d = sel_q;
                data_d = sel_q ? byte_q[3:0] : 4'h0;
            end
            M2: begin
                pend_d = CM_ROM ? 1'b1 : pend_q;
                opa_d = CM_ROM ? DATA_I : opa_q;
            end
            X1: begin
                oe_d = rdr;
                data_d = rdr ? IO_IN : 4'h0;
            end
            X2: begin
                src_d = CM_ROM ? hit : src_q;
                io_d = wrr ? DATA_I : io_q;
            end
            X3: pend_d = 1'b0;
            default: ;
        endcase
        if (abort) begin
            oe_d = 1'b0;
            data_d = 4'h0;
            pend_d = 1'b0;
            sel_d = 1'b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RES) begin
            phase_q <= IDLE;
            addr_q <= 8'h00;
            byte_q <= 8'h00;
            sel_q <= 1'b0;
            src_q <= 1'b0;
            pend_q <= 1'b0;
            opa_q <= 4'h0;
            io_q <= IO_RST;
            data_q <= 4'h0;
            oe_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            addr_q <= addr_d;
            byte_q <= byte_d;
            sel_q <= sel_d;
            src_q <= src_d;
            pend_q <= pend_d;
            opa_q <= opa_d;
            io_q <= io_d;
            data_q <= data_d;
            oe_q <= oe_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (LD_WE) mem_q[LD_ADDR] <= LD_DATA;
    end
endmodule

// File: tb/tb_rom_responder.sv
// tb_rom_responder: drives whole instruction cycles and compares each phase's bus drive and IO_OUT
// against an instruction-level model of the ROM contents, SRC selection and output port.
module tb_rom_responder;
    localparam logic [3:0] ID = 4'h3;
    localparam logic [3:0] IRST = 4'h5;
    logic CLK = 1'b0, RES, SYNC, CM_ROM, LD_WE, DATA_OE;
    logic [3:0] DATA_I, DATA_O, IO_IN, IO_OUT;
    logic [7:0] LD_ADDR, LD_DATA;
    int checks = 0, errors = 0;
    logic [7:0] mem [256];
    logic src_m;
    logic [3:0] io_m;
    logic [4:0] obs [8];
    logic [4:0] exp_v [8];

    always #5 CLK = ~CLK;

    rom_responder #(.CHIP_ID(ID), .IO_RST(IRST)) dut (
        .CLK(CLK), .RES(RES), .SYNC(SYNC), .CM_ROM(CM_ROM), .DATA_I(DATA_I),
        .DATA_O(DATA_O), .DATA_OE(DATA_OE), .IO_IN(IO_IN), .IO_OUT(IO_OUT),
        .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
    );

    task automatic step(input logic s, input logic c, input logic [3:0] d);
        SYNC = s;
        CM_ROM = c;
        DATA_I = d;
        @(posedge CLK);
        #1;
    endtask

    // One full instruction starting in A1; obs[p] is the bus after the edge ending drive phase p.
    task automatic run_instr(input logic [7:0] a, input logic [3:0] chip, input logic m2c,
                             input logic [3:0] opa, input logic x2c, input logic [3:0] x2d,
                             input logic [3:0] ioin, input int ldp, input logic [7:0] lda,
                             input logic [7:0] ldd, input logic endsync);
        logic [7:0] b;
        logic rdr;
        if (ldp >= 0 && ldp < 2) mem[lda] = ldd;
        b = mem[a];
        if (ldp >= 2) mem[lda] = ldd;
        rdr = m2c && opa == 4'hA && src_m;
        for (int p = 0; p < 8; p++) exp_v[p] = 5'h00;
        if (chip == ID) begin
            exp_v[2] = {1'b1, b[7:4]};
            exp_v[3] = {1'b1, b[3:0]};
        end
        if (rdr) exp_v[5] = {1'b1, ioin};
        if (m2c && opa == 4'h2 && src_m) io_m = x2d;
        if (x2c) src_m = x2d == ID;
        for (int p = 0; p < 8; p++) begin
            LD_WE = p == ldp;
            LD_ADDR = lda;
            LD_DATA = ldd;
            IO_IN = p == 5 ? ioin : 4'($urandom);
            case (p)
                0: step(0, 0, a[3:0]);
                1: step(0, 0, a[7:4]);
                2: step(0, 0, chip);
                3: step(0, 0, 4'($urandom));
                4: step(0, m2c, opa);
                5: step(0, 0, 4'($urandom));
                6: step(0, x2c, x2d);
                default: step(endsync, 0, 4'($urandom));
            endcase
            obs[p] = {DATA_OE, DATA_O};
        end
        LD_WE = 1'b0;
    endtask

    task automatic test_reset();
        RES = 1; SYNC = 0; CM_ROM = 0; DATA_I = 0; LD_WE = 0; IO_IN = 0; LD_ADDR = 0; LD_DATA = 0;
        repeat (2) step(0, 0, 0);
        checks++;
        if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL reset_bus: got %h expected 00", {DATA_OE, DATA_O}); end
        checks++;
        if (IO_OUT !== IRST) begin errors++; $display("FAIL reset_io: got %h expected %h", IO_OUT, IRST); end
        RES = 0;
        for (int i = 0; i < 256; i++) begin
            LD_WE = 1;
            LD_ADDR = 8'(i);
            LD_DATA = i == 8'h5A ? 8'hC7 : 8'($urandom);
            mem[i] = LD_DATA;
            step(0, 0, 4'($urandom));
        end
        LD_WE = 0;
        checks++;
        if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL idle_bus: got %h expected 00", {DATA_OE, DATA_O}); end
        src_m = 0;
        io_m = IRST;
        step(1, 0, 0);
    endtask

    task automatic test_fetch_hit();
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, -1, 8'h00, 8'h00, 1);
        checks += 2;
        if (obs[2] !== 5'h1C) begin errors++; $display("FAIL hit_m1: got %h expected 1c", obs[2]); end
        if (obs[3] !== 5'h17) begin errors++; $display("FAIL hit_m2: got %h expected 17", obs[3]); end
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== exp_v[p]) begin errors++; $display("FAIL hit phase %0d: got %h expected %h", p, obs[p], exp_v[p]); end
        end
    endtask

    task automatic test_fetch_miss();
        run_instr(8'h5A, 4'h2, 0, 0, 0, 0, 4'h0, -1, 8'h00, 8'h00, 1);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== 5'h00) begin errors++; $display("FAIL miss phase %0d: got %h expected 00", p, obs[p]); end
        end
    endtask

    task automatic test_src_wrr();
        run_instr(8'h10, 4'h0, 0, 0, 1, ID, 4'h0, -1, 8'h00, 8'h00, 1);
        run_instr(8'h11, 4'h0, 1, 4'h2, 0, 4'h9, 4'h0, -1, 8'h00, 8'h00, 1);
        checks++;
        if (IO_OUT !== 4'h9) begin errors++; $display("FAIL wrr_sel: got %h expected 9", IO_OUT); end
        run_instr(8'h12, 4'h0, 0, 0, 1, 4'h1, 4'h0, -1, 8'h00, 8'h00, 1);
        run_instr(8'h13, 4'h0, 1, 4'h2, 0, 4'h4, 4'h0, -1, 8'h00, 8'h00, 1);
        checks++;
        if (IO_OUT !== 4'h9) begin errors++; $display("FAIL wrr_unsel: got %h expected 9", IO_OUT); end
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== 5'h00) begin errors++; $display("FAIL wrr_unsel phase %0d: got %h expected 00", p, obs[p]); end
        end
    endtask

    task automatic test_rdr();
        run_instr(8'h20, 4'h0, 0, 0, 1, ID, 4'h0, -1, 8'h00, 8'h00, 1);
        run_instr(8'h21, 4'h0, 1, 4'hA, 0, 4'h0, 4'h6, -1, 8'h00, 8'h00, 1);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== (p == 5 ? 5'h16 : 5'h00)) begin
                errors++;
                $display("FAIL rdr phase %0d: got %h expected %h", p, obs[p], p == 5 ? 5'h16 : 5'h00);
            end
        end
    endtask

    task automatic test_abort();
        step(0, 0, 4'hA); step(0, 0, 4'h5); step(0, 0, ID);
        checks++;
        if ({DATA_OE, DATA_O} !== {1'b1, mem[8'h5A][7:4]}) begin
            errors++; $display("FAIL abort_pre: got %h expected %h", {DATA_OE, DATA_O}, {1'b1, mem[8'h5A][7:4]});
        end
        step(1, 0, 0);
        checks++;
        if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL abort_m1: got %h expected 00", {DATA_OE, DATA_O}); end
        run_instr(8'h5A, ID, 0, 0, 1, ID, 4'h0, -1, 8'h00, 8'h00, 0);
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, -1, 8'h00, 8'h00, 1);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== exp_v[p]) begin errors++; $display("FAIL wrap phase %0d: got %h expected %h", p, obs[p], exp_v[p]); end
        end
        step(0, 0, 4'h1); step(0, 0, 4'h1); step(0, 0, 4'h0); step(0, 0, 4'h0); step(0, 1, 4'hA);
        IO_IN = 4'hF;
        step(1, 0, 0);
        checks++;
        if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL abort_rdr: got %h expected 00", {DATA_OE, DATA_O}); end
    endtask

    task automatic test_load_collision();
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, 2, 8'h5A, 8'h11, 1);
        checks += 2;
        if (obs[2] !== 5'h1C) begin errors++; $display("FAIL coll_a3_hi: got %h expected 1c", obs[2]); end
        if (obs[3] !== 5'h17) begin errors++; $display("FAIL coll_a3_lo: got %h expected 17", obs[3]); end
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, 3, 8'h5A, 8'h22, 1);
        checks += 2;
        if (obs[2] !== 5'h11) begin errors++; $display("FAIL coll_m1_hi: got %h expected 11", obs[2]); end
        if (obs[3] !== 5'h11) begin errors++; $display("FAIL coll_m1_lo: got %h expected 11", obs[3]); end
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, -1, 8'h00, 8'h00, 1);
        checks++;
        if (obs[3] !== 5'h12) begin errors++; $display("FAIL coll_next: got %h expected 12", obs[3]); end
    endtask

    task automatic test_reset_mid();
        run_instr(8'h30, 4'h0, 0, 0, 1, ID, 4'h0, -1, 8'h00, 8'h00, 1);
        run_instr(8'h31, 4'h0, 1, 4'h2, 0, 4'h9, 4'h0, -1, 8'h00, 8'h00, 1);
        step(0, 0, 4'hA); step(0, 0, 4'h5); step(0, 0, ID); step(0, 0, 0);
        RES = 1;
        step(0, 1, 4'hA);
        RES = 0;
        checks += 2;
        if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL res_mid_bus: got %h expected 00", {DATA_OE, DATA_O}); end
        if (IO_OUT !== IRST) begin errors++; $display("FAIL res_mid_io: got %h expected %h", IO_OUT, IRST); end
        io_m = IRST;
        src_m = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, i == 2 ? ID : 4'($urandom));
            checks++;
            if ({DATA_OE, DATA_O} !== 5'h00) begin errors++; $display("FAIL res_idle %0d: got %h expected 00", i, {DATA_OE, DATA_O}); end
        end
        step(1, 0, 0);
        run_instr(8'h5A, ID, 0, 0, 0, 0, 4'h0, -1, 8'h00, 8'h00, 1);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (obs[p] !== exp_v[p]) begin errors++; $display("FAIL res_recover phase %0d: got %h expected %h", p, obs[p], exp_v[p]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a, lda;
            logic [3:0] opa;
            int ldp;
            a = 8'($urandom);
            lda = $urandom_range(0, 1) ? a : 8'($urandom);
            opa = $urandom_range(0, 2) == 0 ? 4'h2 : $urandom_range(0, 1) ? 4'hA : 4'($urandom);
            ldp = int'($urandom_range(0, 9)) - 2;
            run_instr(a, $urandom_range(0, 1) ? ID : 4'($urandom), 1'($urandom), opa, 1'($urandom),
                      $urandom_range(0, 1) ? ID : 4'($urandom), 4'($urandom), ldp, lda, 8'($urandom),
                      1'($urandom_range(0, 3) != 0));
            for (int p = 0; p < 8; p++) begin
                checks++;
                if (obs[p] !== exp_v[p]) begin errors++; $display("FAIL rand %0d phase %0d: got %h expected %h", n, p, obs[p], exp_v[p]); end
            end
            checks++;
            if (IO_OUT !== io_m) begin errors++; $display("FAIL rand %0d io: got %h expected %h", n, IO_OUT, io_m); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_hit();
        test_fetch_miss();
        test_src_wrr();
        test_rdr();
        test_abort();
        test_load_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
